// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: controller states
// and the default parameter values used by the top and the read-port mux.
package reg_file_mp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_PC_IDX   = 9;

endpackage

// File: rtl/reg_file_mp_rdport.sv
// One combinational read port of reg_file_mp: selects pcPlus8 for the PC
// index, zero while the file is being swept, otherwise the stored value and
// its pending flag. Optional same-cycle write bypass: REG_FILE_MP_BYPASS_EN.
module reg_file_mp_rdport
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_NUM_REGS),
  parameter int PC_IDX = DEF_PC_IDX
) (
  input  logic              isReady,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regValue,
  input  logic              pendBit,
  input  logic [DATA_W-1:0] pcPlus8,
`ifdef REG_FILE_MP_BYPASS_EN
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
`endif
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic              bypassHit;
  logic [DATA_W-1:0] bypassData;

`ifdef REG_FILE_MP_BYPASS_EN
  assign bypassHit  = writeEnable && (writeAddr == addr);
  assign bypassData = writeData;
`else
  assign bypassHit  = 1'b0;
  assign bypassData = '0;
`endif

  // PC index wins, then sweep blanking, then bypass, then stored value.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (addr == PC_ADDR) begin
      data = pcPlus8;
    end else if (isReady) begin
      if (bypassHit) begin
        data = bypassData;
      end else begin
        data = regValue;
        busy = pendBit;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with pending-write scoreboard. After reset or a
// clearReq pulse, a sweep zeroes one register per cycle before ready rises.
// Optional same-cycle write-to-read bypass: REG_FILE_MP_BYPASS_EN.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int PC_IDX   = DEF_PC_IDX,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       writeEnable,
  input  logic [ADDR_W-1:0]          writeAddr,
  input  logic [DATA_W-1:0]          writeData,
  input  logic                       reserveEnable,
  input  logic [ADDR_W-1:0]          reserveAddr,
  input  logic                       clearReq,
  input  logic [NUM_RD*ADDR_W-1:0]   readAddr,
  output logic [NUM_RD*DATA_W-1:0]   readData,
  output logic [NUM_RD-1:0]          readBusy,
  input  logic [DATA_W-1:0]          pcPlus8,
  output logic                       ready
);

  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clrIdx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;

  logic isReady;
  logic doWrite;
  logic doReserve;

  assign isReady   = (state == READY);
  assign ready     = isReady;
  assign doWrite   = isReady && !clearReq && writeEnable   && (writeAddr   != PC_ADDR);
  assign doReserve = isReady && !clearReq && reserveEnable && (reserveAddr != PC_ADDR);

  // Controller: sweep through every index once, then serve until clearReq.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= CLEAR;
      clrIdx <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clrIdx <= clrIdx + 1'b1;
          if (clrIdx == LAST_IDX) state <= READY;
        end
        READY: begin
          if (clearReq) begin
            state  <= CLEAR;
            clrIdx <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage and scoreboard: no wide reset, the sweep does the zeroing; a
  // reserve is applied after the write so it wins on the same index.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!isReady) begin
        regs[clrIdx]    <= '0;
        pending[clrIdx] <= 1'b0;
      end else begin
        if (doWrite) begin
          regs[writeAddr]    <= writeData;
          pending[writeAddr] <= 1'b0;
        end
        if (doReserve) pending[reserveAddr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    logic [ADDR_W-1:0] addr;
    assign addr = readAddr[i*ADDR_W +: ADDR_W];

    reg_file_mp_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .PC_IDX (PC_IDX)
    ) uPort (
      .isReady     (isReady),
      .addr        (addr),
      .regValue    (regs[addr]),
      .pendBit     (pending[addr]),
      .pcPlus8     (pcPlus8),
`ifdef REG_FILE_MP_BYPASS_EN
      .writeEnable (writeEnable),
      .writeAddr   (writeAddr),
      .writeData   (writeData),
`endif
      .data        (readData[i*DATA_W +: DATA_W]),
      .busy        (readBusy[i])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp with default parameters.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        writeEnable;
  logic [3:0]  writeAddr;
  logic [31:0] writeData;
  logic        reserveEnable;
  logic [3:0]  reserveAddr;
  logic        clearReq;
  logic [7:0]  readAddr;
  logic [63:0] readData;
  logic [1:0]  readBusy;
  logic [31:0] pcPlus8;
  logic        ready;

  int totalChecks = 0;
  int badChecks   = 0;
  int cycles;

`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .writeEnable   (writeEnable),
    .writeAddr     (writeAddr),
    .writeData     (writeData),
    .reserveEnable (reserveEnable),
    .reserveAddr   (reserveAddr),
    .clearReq      (clearReq),
    .readAddr      (readAddr),
    .readData      (readData),
    .readBusy      (readBusy),
    .pcPlus8       (pcPlus8),
    .ready         (ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic re, input logic [3:0] ra, input logic clr);
    writeEnable   = we;
    writeAddr     = wa;
    writeData     = wd;
    reserveEnable = re;
    reserveAddr   = ra;
    clearReq      = clr;
  endtask

  task automatic setRead(input logic [3:0] a0, input logic [3:0] a1);
    readAddr = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    pcPlus8 = 32'h108;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    setRead(4'd0, 4'd0);
    repeat (3) tick();

    // reset release and sweep length
    checkOutput("ready_in_reset", {31'b0, ready}, 32'd0);
    rst_n = 1'b1;
    waitReady(cycles);
    checkOutput("reset_sweep_len", cycles, 32'd16);

    // every register reads zero and not busy
    for (int r = 0; r < 16; r++) begin
      setRead(4'(r), 4'(r));
      #1;
      checkOutput($sformatf("init_rd0_r%0d", r), readData[31:0], (r == 9) ? 32'h108 : 32'h0);
      checkOutput($sformatf("init_busy_r%0d", r), {30'b0, readBusy}, 32'd0);
    end

    // write r3, check latency
    setRead(4'd3, 4'd3);
    applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("wr_r3_same_cycle", readData[31:0], BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("wr_r3_next_p0", readData[31:0], 32'hDEADBEEF);
    checkOutput("wr_r3_next_p1", readData[63:32], 32'hDEADBEEF);

    // scoreboard on r5
    setRead(4'd5, 4'd5);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0);
    #1;
    checkOutput("rsv_r5_before_edge", {30'b0, readBusy}, 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("rsv_r5_busy", {30'b0, readBusy}, 32'd3);
    applyStimulus(1'b1, 4'd5, 32'h12, 1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("wr_r5_same_busy", {30'b0, readBusy}, BYP ? 32'd0 : 32'd3);
    checkOutput("wr_r5_same_data", readData[31:0], BYP ? 32'h12 : 32'h0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("wr_r5_busy_clr", {30'b0, readBusy}, 32'd0);
    checkOutput("wr_r5_data", readData[31:0], 32'h12);
    applyStimulus(1'b1, 4'd5, 32'h34, 1'b1, 4'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("wr_rsv_r5_busy", {30'b0, readBusy}, 32'd3);
    checkOutput("wr_rsv_r5_data", readData[31:0], 32'h34);

    // PC index
    setRead(4'd9, 4'd9);
    #1;
    checkOutput("pc_p0", readData[31:0], 32'h108);
    checkOutput("pc_p1", readData[63:32], 32'h108);
    applyStimulus(1'b1, 4'd9, 32'h55, 1'b1, 4'd9, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    pcPlus8 = 32'h200;
    setRead(4'd9, 4'd5);
    #1;
    checkOutput("pc_after_wr", readData[31:0], 32'h200);
    checkOutput("pc_busy_mixed", {30'b0, readBusy}, 32'd2);
    checkOutput("pc_p1_r5", readData[63:32], 32'h34);

    // clearReq sweep, write during sweep lost
    applyStimulus(1'b1, 4'd1, 32'h7, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    setRead(4'd1, 4'd3);
    #1;
    checkOutput("r1_before_clear", readData[31:0], 32'h7);
    applyStimulus(1'b1, 4'd2, 32'hAA, 1'b0, 4'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd4, 32'h99, 1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("clear_ready_low", {31'b0, ready}, 32'd0);
    checkOutput("clear_rd_zero", readData[31:0], 32'h0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    waitReady(cycles);
    checkOutput("clear_sweep_len", cycles + 1, 32'd16);
    #1;
    checkOutput("r1_after_clear", readData[31:0], 32'h0);
    checkOutput("r3_after_clear", readData[63:32], 32'h0);
    setRead(4'd2, 4'd4);
    #1;
    checkOutput("r2_write_dropped", readData[31:0], 32'h0);
    checkOutput("r4_sweep_write_lost", readData[63:32], 32'h0);
    setRead(4'd5, 4'd5);
    #1;
    checkOutput("r5_busy_after_clear", {30'b0, readBusy}, 32'd0);

    // reset in the middle of a sweep
    applyStimulus(1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midsweep_reset_ready", {31'b0, ready}, 32'd0);
    rst_n = 1'b1;
    waitReady(cycles);
    checkOutput("midsweep_restart_len", cycles, 32'd16);
    setRead(4'd6, 4'd6);
    #1;
    checkOutput("r6_after_restart", readData[31:0], 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
